// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbitration bus between the pipeline requesters/ID stage and the
// RegFile write arbiter.
//   master : drives EX/MEM write requests and the two ID lookup addresses,
//            observes the RegFile write port, stall and forwarding results
//   slave  : the arbiter side (regfile_wr_arbiter)
interface regfile_wr_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              exWr;
   logic [ADDR_W-1:0] exAddr;
   logic [DATA_W-1:0] exData;
   logic              memWr;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memData;
   logic              we;
   logic [ADDR_W-1:0] wAddr;
   logic [DATA_W-1:0] wData;
   logic              stall;
   logic [ADDR_W-1:0] rdAddrA;
   logic [ADDR_W-1:0] rdAddrB;
   logic              hitA;
   logic              hitB;
   logic [DATA_W-1:0] fwdA;
   logic [DATA_W-1:0] fwdB;

   modport master (
      output exWr, exAddr, exData, memWr, memAddr, memData, rdAddrA, rdAddrB,
      input  we, wAddr, wData, stall, hitA, hitB, fwdA, fwdB
   );

   modport slave (
      input  exWr, exAddr, exData, memWr, memAddr, memData, rdAddrA, rdAddrB,
      output we, wAddr, wData, stall, hitA, hitB, fwdA, fwdB
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// RegFile write-port arbiter.
// Shares the single RegFile write port between EX (ALU result) and MEM (load
// return). Writes that cannot be issued immediately are parked in an in-order
// circular buffer and drained one per cycle. ID lookups see the youngest
// not-yet-committed value, and stall holds upstream before the buffer fills.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (discards all parked writes)
//   bus  : regfile_wr_arbiter_if.slave
//          exWr/exAddr/exData, memWr/memAddr/memData : write requests
//          we/wAddr/wData   : registered RegFile write port
//          stall            : hold upstream (count >= DEPTH-1)
//          rdAddrA/B        : ID lookup addresses
//          hitA/B, fwdA/B   : youngest pending data for the lookups
module regfile_wr_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wr_arbiter_if.slave bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef logic [PtrW-1:0]   ptr_t;
   typedef logic [CntW-1:0]   cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   addr_t buf_addr_q [DEPTH];
   data_t buf_data_q [DEPTH];
   ptr_t  head_q, head_d;
   ptr_t  tail_q, tail_d, tail_nx;
   cnt_t  count_q, count_d;

   logic  we_q, we_d;
   addr_t waddr_q, waddr_d;
   data_t wdata_q, wdata_d;

   logic  stall;
   logic  mem_v, ex_v, pop;
   logic  push0_v, push1_v;
   addr_t push0_addr, push1_addr;
   data_t push0_data, push1_data;

   logic  hit_a, hit_b;
   data_t fwd_a, fwd_b;
   int unsigned lk_idx;

   assign stall   = (count_q >= cnt_t'(DEPTH - 1));
   // Address 0 is never written; requests under stall violate protocol and are ignored.
   assign mem_v   = bus.memWr && (bus.memAddr != '0) && !stall;
   assign ex_v    = bus.exWr && (bus.exAddr != '0) && !stall;
   assign tail_nx = ptr_inc(tail_q);

   // Program order is buffer, then MEM, then EX: issue the oldest, park the rest.
   always_comb begin
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      pop        = 1'b0;
      push0_v    = 1'b0;
      push0_addr = '0;
      push0_data = '0;
      push1_v    = 1'b0;
      push1_addr = '0;
      push1_data = '0;

      if (count_q != '0) begin
         we_d    = 1'b1;
         waddr_d = buf_addr_q[head_q];
         wdata_d = buf_data_q[head_q];
         pop     = 1'b1;
         if (mem_v) begin
            push0_v    = 1'b1;
            push0_addr = bus.memAddr;
            push0_data = bus.memData;
            if (ex_v) begin
               push1_v    = 1'b1;
               push1_addr = bus.exAddr;
               push1_data = bus.exData;
            end
         end else if (ex_v) begin
            push0_v    = 1'b1;
            push0_addr = bus.exAddr;
            push0_data = bus.exData;
         end
      end else if (mem_v) begin
         we_d    = 1'b1;
         waddr_d = bus.memAddr;
         wdata_d = bus.memData;
         if (ex_v) begin
            push0_v    = 1'b1;
            push0_addr = bus.exAddr;
            push0_data = bus.exData;
         end
      end else if (ex_v) begin
         we_d    = 1'b1;
         waddr_d = bus.exAddr;
         wdata_d = bus.exData;
      end

      head_d = pop ? ptr_inc(head_q) : head_q;
      tail_d = tail_q;
      if (push0_v) tail_d = tail_nx;
      if (push1_v) tail_d = ptr_inc(tail_nx);
      count_d = count_q + cnt_t'(push0_v) + cnt_t'(push1_v) - cnt_t'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Buffer storage needs no reset: entries are only read below count_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push0_v) begin
            buf_addr_q[tail_q] <= push0_addr;
            buf_data_q[tail_q] <= push0_data;
         end
         if (push1_v) begin
            buf_addr_q[tail_nx] <= push1_addr;
            buf_data_q[tail_nx] <= push1_data;
         end
      end
   end

   // Lookup: output register first, then buffer head to tail, so the youngest
   // match overwrites older ones.
   always_comb begin
      hit_a  = 1'b0;
      fwd_a  = '0;
      hit_b  = 1'b0;
      fwd_b  = '0;
      lk_idx = 0;

      if (we_q && (waddr_q == bus.rdAddrA)) begin
         hit_a = 1'b1;
         fwd_a = wdata_q;
      end
      if (we_q && (waddr_q == bus.rdAddrB)) begin
         hit_b = 1'b1;
         fwd_b = wdata_q;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         lk_idx = 32'(head_q) + i;
         if (lk_idx >= DEPTH) lk_idx = lk_idx - DEPTH;
         if (i < 32'(count_q)) begin
            if (buf_addr_q[lk_idx[PtrW-1:0]] == bus.rdAddrA) begin
               hit_a = 1'b1;
               fwd_a = buf_data_q[lk_idx[PtrW-1:0]];
            end
            if (buf_addr_q[lk_idx[PtrW-1:0]] == bus.rdAddrB) begin
               hit_b = 1'b1;
               fwd_b = buf_data_q[lk_idx[PtrW-1:0]];
            end
         end
      end

      if (bus.rdAddrA == '0) begin
         hit_a = 1'b0;
         fwd_a = '0;
      end
      if (bus.rdAddrB == '0) begin
         hit_b = 1'b0;
         fwd_b = '0;
      end
   end

   assign bus.we    = we_q;
   assign bus.wAddr = waddr_q;
   assign bus.wData = wdata_q;
   assign bus.stall = stall;
   assign bus.hitA  = hit_a;
   assign bus.hitB  = hit_b;
   assign bus.fwdA  = fwd_a;
   assign bus.fwdB  = fwd_b;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed stimulus, a queue-based model of the
// pending writes checked every cycle, and hand-computed literal checks.
module tb_regfile_wr_arbiter;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 4;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model: queue of writes not yet issued (oldest at front) plus the output register.
   wr_t         m_q[$];
   logic        m_we    = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;

   logic [31:0] rf_dut [32];
   int          n_cmp = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   bit          log_en = 1'b0;
   int          stall_seen = 0;
   wr_t         issue_log[$];
   wr_t         exp_seq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void m_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (a == 5'd0) return;
      if (m_we && m_waddr == a) begin
         hit = 1'b1;
         d   = m_wdata;
      end
      foreach (m_q[i]) begin
         if (m_q[i].addr == a) begin
            hit = 1'b1;
            d   = m_q[i].data;
         end
      end
   endfunction

   // Called right at the rising edge, with the inputs that were present before it.
   task automatic model_step();
      wr_t all[$];
      wr_t w;
      if (rst) begin
         m_q.delete();
         m_we    = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
         return;
      end
      all = m_q;
      if (m_q.size() < int'(DEPTH) - 1) begin
         if (bus.memWr && bus.memAddr != 5'd0) all.push_back(wr_t'{addr: bus.memAddr, data: bus.memData});
         if (bus.exWr && bus.exAddr != 5'd0) all.push_back(wr_t'{addr: bus.exAddr, data: bus.exData});
      end
      if (all.size() > 0) begin
         w       = all.pop_front();
         m_we    = 1'b1;
         m_waddr = w.addr;
         m_wdata = w.data;
      end else begin
         m_we = 1'b0;
      end
      m_q = all;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                        input logic ew, input logic [4:0] ea, input logic [31:0] ed);
      bus.memWr   = mw;
      bus.memAddr = ma;
      bus.memData = md;
      bus.exWr    = ew;
      bus.exAddr  = ea;
      bus.exData  = ed;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic        eh_a, eh_b;
      logic [31:0] ed_a, ed_b;
      if (chk_en) begin
         m_lookup(bus.rdAddrA, eh_a, ed_a);
         m_lookup(bus.rdAddrB, eh_b, ed_b);
         check("we", 32'(bus.we), 32'(m_we));
         check("wAddr", 32'(bus.wAddr), 32'(m_waddr));
         check("wData", bus.wData, m_wdata);
         check("stall", 32'(bus.stall), 32'(m_q.size() >= int'(DEPTH) - 1));
         check("hitA", 32'(bus.hitA), 32'(eh_a));
         check("fwdA", bus.fwdA, ed_a);
         check("hitB", 32'(bus.hitB), 32'(eh_b));
         check("fwdB", bus.fwdB, ed_b);
         if (bus.we) rf_dut[bus.wAddr] = bus.wData;
         if (log_en && bus.we) issue_log.push_back(wr_t'{addr: bus.wAddr, data: bus.wData});
         if (log_en && bus.stall) stall_seen++;
      end
   end

   initial begin
      int c;
      for (int i = 0; i < 32; i++) rf_dut[i] = '0;
      idle();
      bus.rdAddrA = '0;
      bus.rdAddrB = '0;
      rst = 1'b1;

      // Reset state
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_we", 32'(bus.we), 32'd0);
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_wAddr", 32'(bus.wAddr), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1: single EX write, one-cycle latency
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
      tick();
      idle();
      @(negedge clk);
      check("t1_we", 32'(bus.we), 32'd1);
      check("t1_wAddr", 32'(bus.wAddr), 32'd3);
      check("t1_wData", bus.wData, 32'h11);
      check("t1_stall", 32'(bus.stall), 32'd0);

      // 2: MEM and EX together, MEM first, EX parked then drained
      bus.rdAddrA = 5'd5;
      drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
      tick();
      idle();
      @(negedge clk);
      check("t2_first_wAddr", 32'(bus.wAddr), 32'd4);
      check("t2_first_wData", bus.wData, 32'hA);
      check("t2_parked_hit", 32'(bus.hitA), 32'd1);
      check("t2_parked_fwd", bus.fwdA, 32'hB);
      tick();
      @(negedge clk);
      check("t2_second_we", 32'(bus.we), 32'd1);
      check("t2_second_wAddr", 32'(bus.wAddr), 32'd5);
      check("t2_second_wData", bus.wData, 32'hB);
      tick();
      @(negedge clk);
      check("t2_idle_we", 32'(bus.we), 32'd0);
      check("t2_idle_hit", 32'(bus.hitA), 32'd0);

      // 3: both requesters every cycle unless stalled; order must be preserved
      log_en     = 1'b1;
      stall_seen = 0;
      bus.rdAddrA = 5'd9;
      bus.rdAddrB = 5'd18;
      for (int k = 0; k < 12; k++) begin
         if (m_q.size() >= int'(DEPTH) - 1) begin
            idle();
         end else begin
            drive(1'b1, 5'(8 + k % 8), 32'h100 + 32'(k), 1'b1, 5'(16 + k % 8), 32'h200 + 32'(k));
            exp_seq.push_back(wr_t'{addr: 5'(8 + k % 8), data: 32'h100 + 32'(k)});
            exp_seq.push_back(wr_t'{addr: 5'(16 + k % 8), data: 32'h200 + 32'(k)});
         end
         tick();
      end
      idle();
      c = 0;
      do begin
         tick();
         @(negedge clk);
         c++;
      end while (bus.we && c < 20);
      check("t3_drain_bound", 32'(c < 20), 32'd1);
      log_en = 1'b0;
      check("t3_stall_seen", 32'(stall_seen > 0), 32'd1);
      check("t3_issue_count", 32'(issue_log.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < issue_log.size(); i++) begin
         check("t3_order_addr", 32'(issue_log[i].addr), 32'(exp_seq[i].addr));
         check("t3_order_data", issue_log[i].data, exp_seq[i].data);
      end

      // 4: r7 parked with 1, then MEM r7=2; youngest wins and lands last
      bus.rdAddrA = 5'd7;
      bus.rdAddrB = 5'd6;
      drive(1'b1, 5'd6, 32'd5, 1'b1, 5'd7, 32'd1);
      tick();
      drive(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t4_hitA_old", 32'(bus.hitA), 32'd1);
      check("t4_fwdA_old", bus.fwdA, 32'd1);
      check("t4_fwdB_outreg", bus.fwdB, 32'd5);
      tick();
      idle();
      @(negedge clk);
      check("t4_hitA_young", 32'(bus.hitA), 32'd1);
      check("t4_fwdA_young", bus.fwdA, 32'd2);
      check("t4_hitB_gone", 32'(bus.hitB), 32'd0);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      check("t4_rf_r7", rf_dut[7], 32'd2);

      // 5: address 0 is dropped
      bus.rdAddrA = 5'd0;
      bus.rdAddrB = 5'd0;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
      tick();
      idle();
      @(negedge clk);
      check("t5_we", 32'(bus.we), 32'd0);
      check("t5_hitA", 32'(bus.hitA), 32'd0);
      check("t5_fwdA", bus.fwdA, 32'd0);
      tick();
      @(negedge clk);
      check("t5_no_entry", 32'(bus.we), 32'd0);

      // 6: fill to count 3, reset discards parked writes
      bus.rdAddrA = 5'd30;
      drive(1'b1, 5'd25, 32'h25, 1'b1, 5'd26, 32'h26);
      tick();
      drive(1'b1, 5'd27, 32'h27, 1'b1, 5'd28, 32'h28);
      tick();
      drive(1'b1, 5'd29, 32'h29, 1'b1, 5'd30, 32'h30);
      tick();
      idle();
      @(negedge clk);
      check("t6_stall_full", 32'(bus.stall), 32'd1);
      check("t6_hit_parked", 32'(bus.hitA), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_we", 32'(bus.we), 32'd0);
      check("t6_rst_stall", 32'(bus.stall), 32'd0);
      check("t6_rst_hit", 32'(bus.hitA), 32'd0);
      tick();
      tick();
      @(negedge clk);
      check("t6_no_issue", 32'(bus.we), 32'd0);
      check("t6_rf_r30", rf_dut[30], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
